// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: block FSM encoding,
// block geometry and the big-endian byte-lane helpers used by word writes.
package dmem_pkg;

   localparam int BLK_WORDS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } blk_state_e;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      logic [2:0] s_s;
      if (size == 2'd0) begin
         s_s = 3'd4;
      end else begin
         s_s = {1'b0, size};
      end
      return s_s;
   endfunction

   // Lane mask bit k covers bits [8k+7:8k]; byte lane 0 is bits [31:24].
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [2:0] s_s;
      logic [3:0] ones_s;
      logic [3:0] shamt_s;
      logic [7:0] wide_s;
      s_s     = size_bytes(size);
      ones_s  = 4'b1111 >> (3'd4 - s_s);
      shamt_s = {2'b00, off} + {1'b0, s_s};
      wide_s  = {ones_s, 4'b0000} >> shamt_s;
      return wide_s[3:0];
   endfunction

   // Bytes that would land past lane 3 fall off the bottom of the wide shift.
   function automatic logic [31:0] lane_align(input logic [31:0] data, input logic [1:0] size,
                                              input logic [1:0] off);
      logic [2:0]  s_s;
      logic [5:0]  keep_sh_s;
      logic [3:0]  shamt_s;
      logic [63:0] wide_s;
      s_s       = size_bytes(size);
      keep_sh_s = {3'd4 - s_s, 3'b000};
      shamt_s   = {2'b00, off} + {1'b0, s_s};
      wide_s    = {data & (32'hFFFF_FFFF >> keep_sh_s), 32'h0000_0000} >> {shamt_s, 3'b000};
      return wide_s[31:0];
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: async word read, 8-word block read, byte-masked word write
// and 8-word block write; the block write overrides the word write.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int MEM_WORDS = 4096,
   localparam int IDX_W = $clog2(MEM_WORDS),
   localparam int ROW_W = IDX_W - 3
)(
   input  logic                   clk,
   input  logic [IDX_W-1:0]       word_idx,
   output logic [31:0]            word_rdata,
   input  logic                   word_we,
   input  logic [3:0]             word_mask,
   input  logic [31:0]            word_wdata,
   input  logic [ROW_W-1:0]       blk_row,
   output logic [32*BLK_WORDS-1:0] blk_rdata,
   input  logic                   blk_we,
   input  logic [32*BLK_WORDS-1:0] blk_wdata
);

   logic [31:0] mem_r [MEM_WORDS];

   assign word_rdata = mem_r[word_idx];

   // Gather the eight words of the addressed block onto the wide bus.
   always_comb begin
      blk_rdata = '0;
      for (int i = 0; i < BLK_WORDS; i++) begin
         blk_rdata[32*i +: 32] = mem_r[{blk_row, 3'(i)}];
      end
   end

   // Later non-blocking writes win, so the block port overrides a same-word write.
   always_ff @(posedge clk) begin
      if (word_we) begin
         for (int k = 0; k < 4; k++) begin
            if (word_mask[k]) begin
               mem_r[word_idx][8*k +: 8] <= word_wdata[8*k +: 8];
            end
         end
      end
      if (blk_we) begin
         for (int i = 0; i < BLK_WORDS; i++) begin
            mem_r[{blk_row, 3'(i)}] <= blk_wdata[32*i +: 32];
         end
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MIPS data port: word/partial accesses plus
// fixed-latency 256-bit block transfers. Optional counters under MEM_STATS_EN.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int MEM_WORDS   = 4096,
   parameter int BLK_LATENCY = 4
)(
   input  logic         CLK,
   input  logic         RESET,
   input  logic [31:0]  data_address_fC,
   input  logic         MemRead_fC,
   input  logic         MemWrite_fC,
   input  logic [31:0]  data_write_fC,
   input  logic [1:0]   data_write_size_fC,
   output logic [31:0]  data_read_2C,
   input  logic         dBlkRead_fC,
   input  logic         dBlkWrite_fC,
   input  logic [255:0] block_write_fC,
   output logic [255:0] block_read_2C,
   output logic         block_read_valid_2C,
   output logic         block_write_valid_2C
`ifdef MEM_STATS_EN
   ,
   output logic [31:0]  stat_reads,
   output logic [31:0]  stat_writes,
   output logic [31:0]  stat_blocks
`endif
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int ROW_W = IDX_W - 3;
   localparam logic [3:0] LAT_LOAD = 4'(BLK_LATENCY - 1);

   blk_state_e         state_r, state_s;
   logic [3:0]         cnt_r, cnt_s;
   logic               op_write_r;
   logic [ROW_W-1:0]   blk_row_r;
   logic [255:0]       block_read_r;
   logic               rd_valid_r, wr_valid_r;
   logic               accept_s, commit_s, req_held_s, blk_we_s;
   logic [IDX_W-1:0]   word_idx_s;
   logic [31:0]        word_rdata_s;
   logic [255:0]       blk_rdata_s;
   logic               unused_addr_s;

   assign word_idx_s    = data_address_fC[IDX_W+1:2];
   assign unused_addr_s = ^data_address_fC[31:IDX_W+2];
   assign blk_we_s      = commit_s & op_write_r & RESET;

   dmem_array #(
      .MEM_WORDS (MEM_WORDS)
   ) u_array (
      .clk        (CLK),
      .word_idx   (word_idx_s),
      .word_rdata (word_rdata_s),
      .word_we    (MemWrite_fC),
      .word_mask  (lane_mask(data_write_size_fC, data_address_fC[1:0])),
      .word_wdata (lane_align(data_write_fC, data_write_size_fC, data_address_fC[1:0])),
      .blk_row    (blk_row_r),
      .blk_rdata  (blk_rdata_s),
      .blk_we     (blk_we_s),
      .blk_wdata  (block_write_fC)
   );

   // Word read is combinational and forced to zero when not requested.
   always_comb begin
      if (MemRead_fC) begin
         data_read_2C = word_rdata_s;
      end else begin
         data_read_2C = 32'h0000_0000;
      end
   end

   // Block FSM next state; an abort drops straight back to IDLE.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      accept_s   = 1'b0;
      commit_s   = 1'b0;
      req_held_s = op_write_r ? dBlkWrite_fC : dBlkRead_fC;
      case (state_r)
         IDLE: begin
            if (dBlkWrite_fC || dBlkRead_fC) begin
               state_s  = BUSY;
               cnt_s    = LAT_LOAD;
               accept_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            if (!req_held_s) begin
               state_s = IDLE;
               cnt_s   = 4'd0;
            end else if (cnt_r == 4'd0) begin
               state_s  = DONE;
               commit_s = 1'b1;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // FSM state, latched request and registered completion outputs.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         op_write_r   <= 1'b0;
         blk_row_r    <= '0;
         block_read_r <= 256'd0;
         rd_valid_r   <= 1'b0;
         wr_valid_r   <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         rd_valid_r <= commit_s & ~op_write_r;
         wr_valid_r <= commit_s & op_write_r;
         if (accept_s) begin
            op_write_r <= dBlkWrite_fC;
            blk_row_r  <= word_idx_s[IDX_W-1:3];
         end
         if (commit_s && !op_write_r) begin
            block_read_r <= blk_rdata_s;
         end
      end
   end

   assign block_read_2C        = block_read_r;
   assign block_read_valid_2C  = rd_valid_r;
   assign block_write_valid_2C = wr_valid_r;

`ifdef MEM_STATS_EN
   logic [31:0] stat_reads_r, stat_writes_r, stat_blocks_r;

   // Saturating activity counters.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         stat_reads_r  <= 32'd0;
         stat_writes_r <= 32'd0;
         stat_blocks_r <= 32'd0;
      end else begin
         if (MemRead_fC && (stat_reads_r != 32'hFFFF_FFFF)) begin
            stat_reads_r <= stat_reads_r + 32'd1;
         end
         if (MemWrite_fC && (stat_writes_r != 32'hFFFF_FFFF)) begin
            stat_writes_r <= stat_writes_r + 32'd1;
         end
         if ((rd_valid_r || wr_valid_r) && (stat_blocks_r != 32'hFFFF_FFFF)) begin
            stat_blocks_r <= stat_blocks_r + 32'd1;
         end
      end
   end

   assign stat_reads  = stat_reads_r;
   assign stat_writes = stat_writes_r;
   assign stat_blocks = stat_blocks_r;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: word/partial accesses, block
// latency, write priority, abort and reset-in-busy. Stats checked under MEM_STATS_EN.
module tb_data_mem_responder;

   localparam int MEM_WORDS   = 4096;
   localparam int BLK_LATENCY = 4;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [31:0]  data_address_fC;
   logic         MemRead_fC, MemWrite_fC;
   logic [31:0]  data_write_fC;
   logic [1:0]   data_write_size_fC;
   logic [31:0]  data_read_2C;
   logic         dBlkRead_fC, dBlkWrite_fC;
   logic [255:0] block_write_fC;
   logic [255:0] block_read_2C;
   logic         block_read_valid_2C, block_write_valid_2C;
`ifdef MEM_STATS_EN
   logic [31:0]  stat_reads, stat_writes, stat_blocks;
`endif

   data_mem_responder #(
      .MEM_WORDS   (MEM_WORDS),
      .BLK_LATENCY (BLK_LATENCY)
   ) dut (
      .CLK                  (CLK),
      .RESET                (RESET),
      .data_address_fC      (data_address_fC),
      .MemRead_fC           (MemRead_fC),
      .MemWrite_fC          (MemWrite_fC),
      .data_write_fC        (data_write_fC),
      .data_write_size_fC   (data_write_size_fC),
      .data_read_2C         (data_read_2C),
      .dBlkRead_fC          (dBlkRead_fC),
      .dBlkWrite_fC         (dBlkWrite_fC),
      .block_write_fC       (block_write_fC),
      .block_read_2C        (block_read_2C),
      .block_read_valid_2C  (block_read_valid_2C),
      .block_write_valid_2C (block_write_valid_2C)
`ifdef MEM_STATS_EN
      ,
      .stat_reads           (stat_reads),
      .stat_writes          (stat_writes),
      .stat_blocks          (stat_blocks)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit           is_wr;
      logic [255:0] data;
   } blk_exp_t;

   logic [31:0] word_q [$];
   blk_exp_t    blk_q  [$];
   logic [31:0] model_mem [int];
   int          n_checks  = 0;
   int          n_errors  = 0;
   int          valid_cnt = 0;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic int widx(input logic [31:0] addr);
      return int'((addr >> 2) % MEM_WORDS);
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] addr);
      if (model_mem.exists(widx(addr))) return model_mem[widx(addr)];
      else return 32'hxxxx_xxxx;
   endfunction

   function automatic logic [255:0] model_blk(input logic [31:0] addr);
      logic [255:0] r;
      int base;
      base = widx(addr) & ~7;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = model_mem[base + i];
      return r;
   endfunction

   // Reference write: size s stores the low s bytes, MSB first, from lane off onward.
   function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] data,
                                               input logic [1:0] size, input int off);
      logic [31:0] w;
      int s, lane;
      w = old;
      s = (size == 2'd0) ? 4 : int'(size);
      for (int j = 0; j < s; j++) begin
         lane = off + j;
         if (lane < 4) w[31 - 8*lane -: 8] = data[8*(s - 1 - j) +: 8];
      end
      return w;
   endfunction

   // Block completion monitor pops the scoreboard on every valid pulse.
   always @(negedge CLK) begin
      if (block_read_valid_2C || block_write_valid_2C) begin
         blk_exp_t e;
         valid_cnt++;
         check_val("blk_pending", 256'(blk_q.size() > 0), 256'd1);
         if (blk_q.size() > 0) begin
            e = blk_q.pop_front();
            check_val("blk_kind", 256'(block_write_valid_2C), 256'(e.is_wr));
            if (!e.is_wr) check_val("blk_rdata", block_read_2C, e.data);
         end
      end
   end

   task automatic word_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
      data_address_fC    = addr;
      data_write_fC      = data;
      data_write_size_fC = size;
      MemWrite_fC        = 1'b1;
      tick();
      MemWrite_fC = 1'b0;
      model_mem[widx(addr)] = model_merge(model_rd(addr), data, size, int'(addr[1:0]));
   endtask

   task automatic word_read(input string tag, input logic [31:0] addr);
      data_address_fC = addr;
      MemRead_fC      = 1'b1;
      word_q.push_back(model_rd(addr));
      @(negedge CLK);
      check_val(tag, 256'(data_read_2C), 256'(word_q.pop_front()));
      tick();
      MemRead_fC = 1'b0;
   endtask

   task automatic block_op(input string tag, input bit is_wr, input logic [31:0] addr,
                           input logic [255:0] wdata);
      int  edges;
      bit  seen;
      data_address_fC = addr;
      if (is_wr) begin
         block_write_fC = wdata;
         blk_q.push_back('{1'b1, wdata});
         for (int i = 0; i < 8; i++) model_mem[(widx(addr) & ~7) + i] = wdata[32*i +: 32];
         dBlkWrite_fC = 1'b1;
      end else begin
         blk_q.push_back('{1'b0, model_blk(addr)});
         dBlkRead_fC = 1'b1;
      end
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 64) begin
         @(posedge CLK);
         edges++;
         @(negedge CLK);
         seen = is_wr ? block_write_valid_2C : block_read_valid_2C;
      end
      dBlkWrite_fC = 1'b0;
      dBlkRead_fC  = 1'b0;
      check_val({tag, "_lat"}, 256'(edges), 256'(BLK_LATENCY + 1));
      tick();
   endtask

   initial begin
      logic [255:0] pat;
      int edges, w_edge, r_edge, vc;

      RESET = 1'b0;
      data_address_fC = 32'h0; MemRead_fC = 1'b0; MemWrite_fC = 1'b0;
      data_write_fC = 32'h0; data_write_size_fC = 2'd0;
      dBlkRead_fC = 1'b0; dBlkWrite_fC = 1'b0; block_write_fC = 256'd0;
      tick(); tick();
      check_val("rst_blk_rdata", block_read_2C, 256'd0);
      check_val("rst_rd_valid", 256'(block_read_valid_2C), 256'd0);
      check_val("rst_wr_valid", 256'(block_write_valid_2C), 256'd0);
      check_val("rst_word_rd", 256'(data_read_2C), 256'd0);
      RESET = 1'b1;
      tick();

      // Word and partial writes, wrap and read-during-write
      word_write(32'h100, 32'hDEAD_BEEF, 2'd0);
      word_read("word_rd_100", 32'h100);
      word_write(32'h101, 32'h0000_1234, 2'd2);
      word_read("partial_101", 32'h100);
      check_val("partial_const", 256'(model_rd(32'h100)), 256'(32'hDE12_34EF));
      word_write(32'h103, 32'h00AB_CDEF, 2'd3);
      word_read("drop_103", 32'h100);
      word_write(32'h10A, 32'h0000_0077, 2'd1);
      word_read("wrap_108", 32'h108 + 32'(MEM_WORDS * 4));
      data_address_fC = 32'h100; data_write_fC = 32'h5566_7788; data_write_size_fC = 2'd0;
      MemRead_fC = 1'b1; MemWrite_fC = 1'b1;
      word_q.push_back(model_rd(32'h100));
      @(negedge CLK);
      check_val("rw_pre_data", 256'(data_read_2C), 256'(word_q.pop_front()));
      tick();
      MemRead_fC = 1'b0; MemWrite_fC = 1'b0;
      model_mem[widx(32'h100)] = 32'h5566_7788;
      word_read("rw_post_data", 32'h100);

      // Block round trip
      for (int i = 0; i < 8; i++) pat[32*i +: 32] = 32'(i + 1);
      block_op("blk_wr_200", 1'b1, 32'h200, pat);
      block_op("blk_rd_21c", 1'b0, 32'h21C, 256'd0);
      word_read("word_rd_204", 32'h204);

      // Simultaneous requests: write first, held read later
      for (int i = 0; i < 8; i++) pat[32*i +: 32] = 32'hA000_0000 + 32'(i);
      data_address_fC = 32'h400;
      block_write_fC  = pat;
      blk_q.push_back('{1'b1, pat});
      for (int i = 0; i < 8; i++) model_mem[widx(32'h400) + i] = pat[32*i +: 32];
      blk_q.push_back('{1'b0, model_blk(32'h400)});
      dBlkWrite_fC = 1'b1; dBlkRead_fC = 1'b1;
      edges = 0; w_edge = -1; r_edge = -1;
      while (r_edge < 0 && edges < 80) begin
         @(posedge CLK);
         edges++;
         @(negedge CLK);
         if (block_write_valid_2C) begin
            w_edge = edges;
            dBlkWrite_fC = 1'b0;
         end
         if (block_read_valid_2C) r_edge = edges;
      end
      dBlkRead_fC = 1'b0;
      tick();
      check_val("simul_wr_lat", 256'(w_edge), 256'(BLK_LATENCY + 1));
      check_val("simul_rd_gap", 256'(r_edge - w_edge), 256'(BLK_LATENCY + 2));

      // Abort: known contents at 0x600, then an abandoned write
      for (int i = 0; i < 8; i++) pat[32*i +: 32] = 32'h0600_0000 + 32'(i * 3);
      block_op("blk_wr_600", 1'b1, 32'h600, pat);
      vc = valid_cnt;
      data_address_fC = 32'h600; block_write_fC = ~pat; dBlkWrite_fC = 1'b1;
      tick(); tick();
      dBlkWrite_fC = 1'b0;
      for (int i = 0; i < BLK_LATENCY + 3; i++) tick();
      check_val("abort_no_valid", 256'(valid_cnt), 256'(vc));
      block_op("abort_rd_600", 1'b0, 32'h600, 256'd0);

      // Reset asserted while BUSY
      vc = valid_cnt;
      data_address_fC = 32'h600; block_write_fC = {8{32'hFFFF_0000}}; dBlkWrite_fC = 1'b1;
      tick(); tick();
      RESET = 1'b0; dBlkWrite_fC = 1'b0;
      tick();
      check_val("busyrst_blk_rdata", block_read_2C, 256'd0);
      check_val("busyrst_rd_valid", 256'(block_read_valid_2C), 256'd0);
      check_val("busyrst_wr_valid", 256'(block_write_valid_2C), 256'd0);
      check_val("busyrst_word_rd", 256'(data_read_2C), 256'd0);
      RESET = 1'b1;
      for (int i = 0; i < BLK_LATENCY + 3; i++) tick();
      check_val("busyrst_no_valid", 256'(valid_cnt), 256'(vc));
      block_op("busyrst_rd_600", 1'b0, 32'h600, 256'd0);

`ifdef MEM_STATS_EN
      RESET = 1'b0;
      tick();
      RESET = 1'b1;
      word_read("st_rd0", 32'h100);
      word_read("st_rd1", 32'h200);
      word_read("st_rd2", 32'h204);
      word_write(32'h300, 32'h1111_2222, 2'd0);
      word_write(32'h304, 32'h3333_4444, 2'd0);
      block_op("st_blk", 1'b0, 32'h200, 256'd0);
      check_val("stat_reads", 256'(stat_reads), 256'd3);
      check_val("stat_writes", 256'(stat_writes), 256'd2);
      check_val("stat_blocks", 256'(stat_blocks), 256'd1);
`endif

      check_val("blk_sb_empty", 256'(blk_q.size()), 256'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
